// File: rtl/gpu_bus_regs_pkg.sv
// Shared constants for the GPU host-bus register block: bus widths, register map, bit positions.
package gpu_bus_regs_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 4;

    localparam logic [ADDR_W-1:0] REG_CTRL     = 4'd0;
    localparam logic [ADDR_W-1:0] REG_STATUS   = 4'd1;
    localparam logic [ADDR_W-1:0] REG_PTR_LO   = 4'd2;
    localparam logic [ADDR_W-1:0] REG_PTR_HI   = 4'd3;
    localparam logic [ADDR_W-1:0] REG_DATA     = 4'd4;
    localparam logic [ADDR_W-1:0] REG_INC      = 4'd5;
    localparam logic [ADDR_W-1:0] REG_SCROLL_X = 4'd6;
    localparam logic [ADDR_W-1:0] REG_SCROLL_Y = 4'd7;

    localparam int unsigned CTRL_VBL_IE = 0;
    localparam int unsigned CTRL_OVR_IE = 1;
    localparam int unsigned STAT_VBL    = 0;
    localparam int unsigned STAT_OVR    = 1;

endpackage

// File: rtl/gpu_bus_regs_if.sv
// CPU side of the GPU host bus: asynchronous strobe with address/data/direction, and the irq line.
interface gpu_bus_regs_if;
    import gpu_bus_regs_pkg::*;

    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] addr;
    logic              rw;
    logic              cs_clock;
    logic              irq;

    modport master (output data, addr, rw, cs_clock, input irq);
    modport slave  (input data, addr, rw, cs_clock, output irq);

endinterface

// File: rtl/gpu_bus_regs_strobe_sync.sv
// Brings the asynchronous cs_clock strobe into the system clock and flags its falling edge.
module gpu_bus_regs_strobe_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic cs_clock,
    output logic cs_s,
    output logic commit
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], cs_clock};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign cs_s   = sync_q[SYNC_STAGES-1];
    assign commit = prev_q & ~cs_s;

endmodule

// File: rtl/gpu_bus_regs.sv
// CPU-facing GPU register block: shadows bus accesses, commits writes on strobe fall, feeds VRAM.
module gpu_bus_regs
    import gpu_bus_regs_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned VRAM_AW     = 16,
    parameter int unsigned DEFAULT_INC = 1
) (
    input  logic               CLK100MHz,
    input  logic               rst,
    gpu_bus_regs_if.slave      bus,
    input  logic               frame_start,
    output logic [VRAM_AW-1:0] vram_addr,
    output logic [DATA_W-1:0]  vram_data,
    output logic               vram_valid,
    input  logic               vram_ready,
    output logic [DATA_W-1:0]  ctrl,
    output logic [DATA_W-1:0]  scroll_x,
    output logic [DATA_W-1:0]  scroll_y
);

    logic cs_s, commit;

    gpu_bus_regs_strobe_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_strobe_sync (
        .clk      (CLK100MHz),
        .rst      (rst),
        .cs_clock (bus.cs_clock),
        .cs_s     (cs_s),
        .commit   (commit)
    );

    logic [ADDR_W-1:0]  sh_addr_q;
    logic [DATA_W-1:0]  sh_data_q;
    logic               sh_rw_q;
    logic [DATA_W-1:0]  ctrl_q, scroll_x_q, scroll_y_q, inc_q;
    logic [1:0]         status_q, status_d;
    logic [VRAM_AW-1:0] ptr_q, vram_addr_q;
    logic [DATA_W-1:0]  vram_data_q;
    logic               vram_valid_q, irq_q;

    // Bus fields are only trusted while the synchronised strobe is high.
    always_ff @(posedge CLK100MHz) begin
        if (rst) begin
            sh_addr_q <= '0;
            sh_data_q <= '0;
            sh_rw_q   <= 1'b1;
        end else if (cs_s) begin
            sh_addr_q <= bus.addr;
            sh_data_q <= bus.data;
            sh_rw_q   <= bus.rw;
        end
    end

    logic wr, data_busy;
    assign wr        = commit & ~sh_rw_q;
    assign data_busy = vram_valid_q & ~vram_ready;

    // Hardware sets take priority over the W1C clear.
    always_comb begin
        status_d = status_q;
        if (wr && sh_addr_q == REG_STATUS) status_d = status_q & ~sh_data_q[1:0];
        if (frame_start) status_d[STAT_VBL] = 1'b1;
        if (wr && sh_addr_q == REG_DATA && data_busy) status_d[STAT_OVR] = 1'b1;
    end

    always_ff @(posedge CLK100MHz) begin
        if (rst) begin
            ctrl_q       <= '0;
            scroll_x_q   <= '0;
            scroll_y_q   <= '0;
            inc_q        <= DATA_W'(DEFAULT_INC);
            ptr_q        <= '0;
            status_q     <= '0;
            vram_addr_q  <= '0;
            vram_data_q  <= '0;
            vram_valid_q <= 1'b0;
            irq_q        <= 1'b0;
        end else begin
            if (wr && sh_addr_q == REG_CTRL)     ctrl_q     <= sh_data_q;
            if (wr && sh_addr_q == REG_INC)      inc_q      <= sh_data_q;
            if (wr && sh_addr_q == REG_SCROLL_X) scroll_x_q <= sh_data_q;
            if (wr && sh_addr_q == REG_SCROLL_Y) scroll_y_q <= sh_data_q;
            if (wr && sh_addr_q == REG_PTR_LO)   ptr_q[7:0] <= sh_data_q;
            if (wr && sh_addr_q == REG_PTR_HI)   ptr_q[VRAM_AW-1:8] <= sh_data_q[VRAM_AW-9:0];

            if (wr && sh_addr_q == REG_DATA && !data_busy) begin
                vram_addr_q  <= ptr_q;
                vram_data_q  <= sh_data_q;
                vram_valid_q <= 1'b1;
                ptr_q        <= ptr_q + VRAM_AW'(inc_q);
            end else if (vram_ready) begin
                vram_valid_q <= 1'b0;
            end

            status_q <= status_d;
            irq_q    <= (status_q[STAT_VBL] & ctrl_q[CTRL_VBL_IE]) |
                        (status_q[STAT_OVR] & ctrl_q[CTRL_OVR_IE]);
        end
    end

    assign ctrl       = ctrl_q;
    assign scroll_x   = scroll_x_q;
    assign scroll_y   = scroll_y_q;
    assign vram_addr  = vram_addr_q;
    assign vram_data  = vram_data_q;
    assign vram_valid = vram_valid_q;
    assign bus.irq    = irq_q;

endmodule

// File: tb/tb_gpu_bus_regs.sv
// Directed bench for gpu_bus_regs: strobed CPU writes against hand-computed register/VRAM results.
module tb_gpu_bus_regs;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_start;
    logic        vram_ready;
    logic [15:0] vram_addr;
    logic [7:0]  vram_data;
    logic        vram_valid;
    logic [7:0]  ctrl, scroll_x, scroll_y;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    int unsigned vcount;
    logic [15:0] vaddr_seen;
    logic [7:0]  vdata_seen;

    gpu_bus_regs_if bus ();

    gpu_bus_regs #(
        .SYNC_STAGES (2),
        .VRAM_AW     (16),
        .DEFAULT_INC (1)
    ) dut (
        .CLK100MHz   (clk),
        .rst         (rst),
        .bus         (bus),
        .frame_start (frame_start),
        .vram_addr   (vram_addr),
        .vram_data   (vram_data),
        .vram_valid  (vram_valid),
        .vram_ready  (vram_ready),
        .ctrl        (ctrl),
        .scroll_x    (scroll_x),
        .scroll_y    (scroll_y)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Full strobe; commit lands at the third edge after the fall, frame_start optionally aligned to it.
    task automatic bus_xfer(input logic [3:0] a, input logic [7:0] d, input logic r, input bit fs);
        vcount     = 0;
        vaddr_seen = '0;
        vdata_seen = '0;
        tick(1);
        bus.addr     = a;
        bus.data     = d;
        bus.rw       = r;
        bus.cs_clock = 1'b1;
        tick(4);
        bus.cs_clock = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            @(posedge clk);
            #1;
            if (vram_valid) begin
                if (vcount == 0) begin
                    vaddr_seen = vram_addr;
                    vdata_seen = vram_data;
                end
                vcount++;
            end
            if (i == 2) frame_start = fs;
            if (i == 3) frame_start = 1'b0;
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        bus_xfer(a, d, 1'b0, 1'b0);
    endtask

    initial begin
        rst          = 1'b1;
        frame_start  = 1'b0;
        vram_ready   = 1'b1;
        bus.addr     = '0;
        bus.data     = '0;
        bus.rw       = 1'b1;
        bus.cs_clock = 1'b0;
        tick(3);
        check_eq("rst_valid", vram_valid, 0);
        check_eq("rst_addr", vram_addr, 0);
        check_eq("rst_ctrl", ctrl, 0);
        check_eq("rst_irq", bus.irq, 0);
        rst = 1'b0;
        tick(2);

        // 1: scroll write, then reserved / aliasing addresses leave everything alone
        wr(4'd6, 8'h5A);
        check_eq("t1_scroll_x", scroll_x, 8'h5A);
        wr(4'd9, 8'h03);
        wr(4'd14, 8'hC3);
        wr(4'd15, 8'h77);
        check_eq("t1_rsv_scroll_x", scroll_x, 8'h5A);
        check_eq("t1_rsv_scroll_y", scroll_y, 8'h00);
        check_eq("t1_rsv_ctrl", ctrl, 8'h00);
        check_eq("t1_rsv_irq", bus.irq, 0);
        wr(4'd7, 8'hB4);
        check_eq("t1_scroll_y", scroll_y, 8'hB4);

        // 2: ptr 0x12FF, INC left at its reset value of 1
        wr(4'd2, 8'hFF);
        wr(4'd3, 8'h12);
        wr(4'd4, 8'hAA);
        check_eq("t2_vcount", vcount, 1);
        check_eq("t2_vaddr", vaddr_seen, 16'h12FF);
        check_eq("t2_vdata", vdata_seen, 8'hAA);
        wr(4'd4, 8'hAB);
        check_eq("t2_ptr_next", vaddr_seen, 16'h1300);

        // 3: wrap with INC=2
        wr(4'd2, 8'hFF);
        wr(4'd3, 8'hFF);
        wr(4'd5, 8'h02);
        wr(4'd4, 8'h01);
        check_eq("t3_vaddr0", vaddr_seen, 16'hFFFF);
        wr(4'd4, 8'h02);
        check_eq("t3_vaddr1", vaddr_seen, 16'h0001);
        check_eq("t3_vdata1", vdata_seen, 8'h02);

        // 4: overrun while VRAM stalls; ptr is now 0x0003
        vram_ready = 1'b0;
        wr(4'd0, 8'h02);
        wr(4'd4, 8'h11);
        check_eq("t4_pend_valid", vram_valid, 1);
        check_eq("t4_pend_addr", vram_addr, 16'h0003);
        check_eq("t4_irq_before", bus.irq, 0);
        wr(4'd4, 8'h22);
        check_eq("t4_hold_data", vram_data, 8'h11);
        check_eq("t4_hold_addr", vram_addr, 16'h0003);
        check_eq("t4_ovr_irq", bus.irq, 1);
        vram_ready = 1'b1;
        tick(1);
        check_eq("t4_drain", vram_valid, 0);
        tick(4);
        check_eq("t4_no_replay", vram_valid, 0);
        wr(4'd4, 8'h33);
        check_eq("t4_ptr_kept", vaddr_seen, 16'h0005);
        wr(4'd1, 8'h02);
        check_eq("t4_w1c_ovr", bus.irq, 0);

        // 5: vblank interrupt, W1C, and clear racing a new frame_start
        wr(4'd0, 8'h01);
        check_eq("t5_idle_irq", bus.irq, 0);
        tick(1);
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
        tick(2);
        check_eq("t5_vbl_irq", bus.irq, 1);
        wr(4'd1, 8'h01);
        check_eq("t5_w1c", bus.irq, 0);
        bus_xfer(4'd1, 8'h01, 1'b0, 1'b1);
        check_eq("t5_set_wins", bus.irq, 1);

        // 6: reset with a pending VRAM write and strobe held high; ptr is now 0x0007
        vram_ready = 1'b0;
        wr(4'd4, 8'h55);
        check_eq("t6_pend_addr", vram_addr, 16'h0007);
        wr(4'd2, 8'h80);
        check_eq("t6_ptr_wr_pend", vram_addr, 16'h0007);
        bus.addr     = 4'd6;
        bus.data     = 8'h77;
        bus.rw       = 1'b0;
        bus.cs_clock = 1'b1;
        tick(4);
        rst = 1'b1;
        tick(2);
        check_eq("t6_rst_valid", vram_valid, 0);
        check_eq("t6_rst_vaddr", vram_addr, 0);
        check_eq("t6_rst_vdata", vram_data, 0);
        check_eq("t6_rst_ctrl", ctrl, 0);
        check_eq("t6_rst_scroll", {scroll_x, scroll_y}, 0);
        check_eq("t6_rst_irq", bus.irq, 0);
        rst      = 1'b0;
        bus.addr = 4'd7;
        bus.data = 8'h33;
        vram_ready = 1'b1;
        tick(5);
        check_eq("t6_no_early_commit", {scroll_x, scroll_y}, 0);
        bus.cs_clock = 1'b0;
        tick(6);
        check_eq("t6_late_commit_y", scroll_y, 8'h33);
        check_eq("t6_late_commit_x", scroll_x, 8'h00);
        wr(4'd4, 8'hEE);
        check_eq("t6_ptr_reset", vaddr_seen, 16'h0000);
        bus_xfer(4'd6, 8'h99, 1'b1, 1'b0);
        check_eq("t6_read_scroll", scroll_x, 8'h00);
        bus_xfer(4'd4, 8'h99, 1'b1, 1'b0);
        check_eq("t6_read_data", vcount, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
